// File: rtl/pipeline_run_monitor.sv
// Run monitor for a simulated pipeline: counts cycles and stores, keeps a store trace,
// and latches the termination cause. Define MONITOR_IDLE_DETECT_EN to include the stall detector.
module pipeline_run_monitor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TRACE_DEPTH = 8,
    parameter int unsigned CYCLE_LIMIT = 500,
    parameter int unsigned DONE_ADDR   = 100,
    parameter int unsigned PASS_VALUE  = 25,
    parameter int unsigned IDLE_LIMIT  = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           MemWrite,
    input  logic [XLEN-1:0]                DataAdr,
    input  logic [XLEN-1:0]                WriteData,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_addr,
    output logic [XLEN-1:0]                trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic [31:0]                    cycle_count,
    output logic [31:0]                    write_count,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic                           idle
);

    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        RUN,
        END_PASS,
        END_FAIL,
        END_TIMEOUT,
        END_IDLE
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [XLEN-1:0]   mem_addr [TRACE_DEPTH];
    logic [XLEN-1:0]   mem_data [TRACE_DEPTH];

    logic [31:0]       cycle_inc;
    logic              done_hit;
    logic              pass_hit;
    logic              time_hit;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rd_valid;

    assign cycle_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign done_hit  = MemWrite && (DataAdr == XLEN'(DONE_ADDR));
    assign pass_hit  = (WriteData == XLEN'(PASS_VALUE));
    assign time_hit  = (cycle_inc == 32'(CYCLE_LIMIT));

`ifdef MONITOR_IDLE_DETECT_EN
    logic [31:0] idle_cnt;
    logic [31:0] idle_inc;
    logic        idle_hit;

    assign idle_inc = MemWrite ? 32'd0 : idle_cnt + 32'd1;
    assign idle_hit = (idle_inc == 32'(IDLE_LIMIT));
`else
    assign idle = 1'b0;
`endif

    // Newest entry sits just behind the write pointer; unused slots read as zero.
    assign rd_ptr     = wr_ptr - PTR_W'(1) - trace_idx;
    assign rd_valid   = (CNT_W'(trace_idx) < trace_count);
    assign trace_addr = rd_valid ? mem_addr[rd_ptr] : '0;
    assign trace_data = rd_valid ? mem_data[rd_ptr] : '0;

    // Run FSM, counters, trace buffer and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cycle_count <= '0;
            write_count <= '0;
            wr_ptr      <= '0;
            trace_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
`ifdef MONITOR_IDLE_DETECT_EN
            idle        <= 1'b0;
            idle_cnt    <= '0;
`endif
        end else if (state == RUN) begin
            cycle_count <= cycle_inc;
`ifdef MONITOR_IDLE_DETECT_EN
            idle_cnt    <= idle_inc;
`endif
            if (MemWrite) begin
                write_count      <= write_count + 32'd1;
                mem_addr[wr_ptr] <= DataAdr;
                mem_data[wr_ptr] <= WriteData;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                if (trace_count != CNT_W'(TRACE_DEPTH))
                    trace_count <= trace_count + CNT_W'(1);
            end
            if (done_hit) begin
                state <= pass_hit ? END_PASS : END_FAIL;
                done  <= 1'b1;
                pass  <= pass_hit;
            end else if (time_hit) begin
                state   <= END_TIMEOUT;
                done    <= 1'b1;
                timeout <= 1'b1;
            end
`ifdef MONITOR_IDLE_DETECT_EN
            else if (idle_hit) begin
                state <= END_IDLE;
                done  <= 1'b1;
                idle  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Self-checking bench for pipeline_run_monitor: vector table, directed corner sequences,
// and randomized runs checked against a queue-based reference model.
module tb_pipeline_run_monitor;

    localparam int unsigned XLEN = 32;
    localparam int unsigned D    = 8;
    localparam int unsigned PW   = 3;
    localparam int unsigned CL   = 500;
    localparam int unsigned DA   = 100;
    localparam int unsigned PV   = 25;
    localparam int unsigned IL   = 64;
`ifdef MONITOR_IDLE_DETECT_EN
    localparam bit IDLE_ON = 1'b1;
`else
    localparam bit IDLE_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            MemWrite;
    logic [XLEN-1:0] DataAdr;
    logic [XLEN-1:0] WriteData;
    logic [PW-1:0]   trace_idx;
    logic [XLEN-1:0] trace_addr;
    logic [XLEN-1:0] trace_data;
    logic [PW:0]     trace_count;
    logic [31:0]     cycle_count;
    logic [31:0]     write_count;
    logic            done;
    logic            pass;
    logic            timeout;
    logic            idle;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_run_monitor #(
        .XLEN(XLEN), .TRACE_DEPTH(D), .CYCLE_LIMIT(CL),
        .DONE_ADDR(DA), .PASS_VALUE(PV), .IDLE_LIMIT(IL)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .trace_idx(trace_idx), .trace_addr(trace_addr),
        .trace_data(trace_data), .trace_count(trace_count), .cycle_count(cycle_count),
        .write_count(write_count), .done(done), .pass(pass), .timeout(timeout), .idle(idle)
    );

    // Reference model: 0 running, 1 pass, 2 fail, 3 timeout, 4 idle
    longint          m_cyc;
    int              m_wr;
    int              m_state;
    int              m_idle;
    logic [31:0]     q_addr[$];
    logic [31:0]     q_data[$];

    task automatic model_step();
        if (reset) begin
            m_cyc = 0; m_wr = 0; m_state = 0; m_idle = 0;
            q_addr.delete(); q_data.delete();
        end else if (m_state == 0) begin
            m_cyc = (m_cyc == 64'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
            if (MemWrite) begin
                m_wr++;
                q_addr.push_front(DataAdr);
                q_data.push_front(WriteData);
                if (q_addr.size() > D) begin
                    void'(q_addr.pop_back());
                    void'(q_data.pop_back());
                end
                m_idle = 0;
            end else begin
                m_idle++;
            end
            if (MemWrite && DataAdr == DA) m_state = (WriteData == PV) ? 1 : 2;
            else if (m_cyc == CL)          m_state = 3;
            else if (IDLE_ON && m_idle == IL) m_state = 4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        int i;
        i = int'(trace_idx);
        chk("m_done",    64'(done),        64'(m_state != 0));
        chk("m_pass",    64'(pass),        64'(m_state == 1));
        chk("m_timeout", 64'(timeout),     64'(m_state == 3));
        chk("m_idle",    64'(idle),        64'(m_state == 4));
        chk("m_cycles",  64'(cycle_count), 64'(m_cyc));
        chk("m_writes",  64'(write_count), 64'(m_wr));
        chk("m_tcount",  64'(trace_count), 64'(q_addr.size()));
        chk("m_taddr",   64'(trace_addr),  (i < q_addr.size()) ? 64'(q_addr[i]) : 64'd0);
        chk("m_tdata",   64'(trace_data),  (i < q_data.size()) ? 64'(q_data[i]) : 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  idx;
        logic        done;
        logic        pass;
        int          tcount;
        int          wcount;
        logic [31:0] taddr;
        logic [31:0] tdata;
    } vec_t;

    vec_t tbl[15];

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; trace_idx = '0;

        // Vector table: reset, ten stores wrapping the trace, DONE_ADDR fail, frozen store, reset
        tbl[0] = '{1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 0, 0, 32'd0, 32'd0};
        for (int k = 0; k < 10; k++)
            tbl[1+k] = '{1'b0, 1'b1, 32'(4*k), 32'(k), 3'd0, 1'b0, 1'b0,
                         (k < 8) ? k + 1 : 8, k + 1, 32'(4*k), 32'(k)};
        tbl[11] = '{1'b0, 1'b0, 32'd0,   32'd0,  3'd7, 1'b0, 1'b0, 8, 10, 32'd8,   32'd2};
        tbl[12] = '{1'b0, 1'b1, 32'd100, 32'd7,  3'd0, 1'b1, 1'b0, 8, 11, 32'd100, 32'd7};
        tbl[13] = '{1'b0, 1'b1, 32'd5,   32'd5,  3'd0, 1'b1, 1'b0, 8, 11, 32'd100, 32'd7};
        tbl[14] = '{1'b1, 1'b1, 32'd100, 32'd25, 3'd0, 1'b0, 1'b0, 0, 0,  32'd0,   32'd0};

        for (int v = 0; v < 15; v++) begin
            reset = tbl[v].rst; MemWrite = tbl[v].we;
            DataAdr = tbl[v].adr; WriteData = tbl[v].dat; trace_idx = tbl[v].idx;
            tick();
            chk("tbl_done",    64'(done),        64'(tbl[v].done));
            chk("tbl_pass",    64'(pass),        64'(tbl[v].pass));
            chk("tbl_timeout", 64'(timeout),     64'd0);
            chk("tbl_tcount",  64'(trace_count), 64'(tbl[v].tcount));
            chk("tbl_wcount",  64'(write_count), 64'(tbl[v].wcount));
            chk("tbl_taddr",   64'(trace_addr),  64'(tbl[v].taddr));
            chk("tbl_tdata",   64'(trace_data),  64'(tbl[v].tdata));
        end
        reset = 1'b0; MemWrite = 1'b0; trace_idx = '0;

        // Pass store on the 5th edge after reset, then hold
        do_reset();
        repeat (4) tick();
        chk("pass_pre_done", 64'(done), 64'd0);
        MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd25;
        tick();
        MemWrite = 1'b0;
        chk("pass_done",   64'(done),        64'd1);
        chk("pass_pass",   64'(pass),        64'd1);
        chk("pass_wcount", 64'(write_count), 64'd1);
        chk("pass_cycles", 64'(cycle_count), 64'd5);
        repeat (20) tick();
        chk("pass_hold_pass",   64'(pass),        64'd1);
        chk("pass_hold_cycles", 64'(cycle_count), 64'd5);
        chk("pass_hold_wcount", 64'(write_count), 64'd1);

        // One-edge reset out of END_PASS
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_done",   64'(done),        64'd0);
        chk("rst_pass",   64'(pass),        64'd0);
        chk("rst_cycles", 64'(cycle_count), 64'd0);
        chk("rst_wcount", 64'(write_count), 64'd0);
        chk("rst_tcount", 64'(trace_count), 64'd0);
        tick();
        chk("rst_resume", 64'(cycle_count), 64'd1);

        // Timeout at CYCLE_LIMIT, with a store every 10 cycles
        do_reset();
        for (int e = 1; e <= 500; e++) begin
            MemWrite = (e % 10 == 0); DataAdr = 32'd4; WriteData = 32'(e);
            tick();
            if (e == 499) chk("to_pre_done", 64'(done), 64'd0);
        end
        chk("to_timeout", 64'(timeout),     64'd1);
        chk("to_done",    64'(done),        64'd1);
        chk("to_pass",    64'(pass),        64'd0);
        chk("to_idle",    64'(idle),        64'd0);
        chk("to_cycles",  64'(cycle_count), 64'd500);
        chk("to_wcount",  64'(write_count), 64'd50);
        MemWrite = 1'b1;
        repeat (5) tick();
        MemWrite = 1'b0;
        chk("to_frozen_cycles", 64'(cycle_count), 64'd500);
        chk("to_frozen_wcount", 64'(write_count), 64'd50);

        // DONE_ADDR store on the timeout edge wins
        do_reset();
        for (int e = 1; e <= 500; e++) begin
            MemWrite = (e % 10 == 0);
            DataAdr = (e == 500) ? 32'd100 : 32'd4;
            WriteData = (e == 500) ? 32'd7 : 32'(e);
            tick();
        end
        MemWrite = 1'b0;
        chk("prio_done",    64'(done),        64'd1);
        chk("prio_pass",    64'(pass),        64'd0);
        chk("prio_timeout", 64'(timeout),     64'd0);
        chk("prio_cycles",  64'(cycle_count), 64'd500);
        chk("prio_taddr",   64'(trace_addr),  64'd100);

        // Stall detector
        do_reset();
`ifdef MONITOR_IDLE_DETECT_EN
        MemWrite = 1'b1; DataAdr = 32'd4; WriteData = 32'd1;
        tick();
        MemWrite = 1'b0;
        repeat (63) tick();
        chk("idle_pre", 64'(idle), 64'd0);
        tick();
        chk("idle_set",    64'(idle),        64'd1);
        chk("idle_done",   64'(done),        64'd1);
        chk("idle_cycles", 64'(cycle_count), 64'd65);
`else
        repeat (200) tick();
        chk("noidle_idle",   64'(idle),        64'd0);
        chk("noidle_done",   64'(done),        64'd0);
        chk("noidle_cycles", 64'(cycle_count), 64'd200);
`endif

        // Randomized runs against the reference model
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int c = 0; c < 700; c++) begin
                reset = ($urandom % 300 == 0);
                MemWrite = ($urandom % 4 == 0);
                if ($urandom % 60 == 0) DataAdr = 32'd100;
                else DataAdr = 32'($urandom % 64) * 32'd4;
                if (DataAdr == 32'd100) WriteData = ($urandom % 2 == 0) ? 32'd25 : 32'($urandom % 50);
                else WriteData = $urandom;
                trace_idx = PW'($urandom % D);
                tick();
                chk_model();
            end
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
